// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures one parallel FFT frame on a load pulse and
// streams it out one sample per valid/ready handshake, in natural or
// bit-reversed slot order. A load that lands on the final transfer starts
// the next frame without a bubble. Any other load during a stream is dropped
// and raises a sticky overrun flag.
module fft_out_serializer #(
  parameter int N      = 32,
  parameter int MSB    = 16,
  parameter bit BITREV = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [N*MSB-1:0]      data_in,
  input  logic                  out_ready,
  output logic [MSB-1:0]        data_out,
  output logic                  out_valid,
  output logic [$clog2(N)-1:0]  out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overrun
);

  localparam int              KW     = $clog2(N);
  localparam logic [KW-1:0]   K_LAST = KW'(N - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t           state_reg;
  logic [KW-1:0]    k_reg;
  logic [MSB-1:0]   data_out_reg;
  logic             last_reg;
  logic             overrun_reg;
  logic [MSB-1:0]   frame_reg [N];

  logic [KW-1:0]    k_next;
  logic [KW-1:0]    slot_next;
  logic             xfer;
  logic             final_xfer;
  logic             capture;

  assign k_next = k_reg + KW'(1);

  // Map the next ordinal onto the frame slot that must be emitted for it.
  generate
    for (genvar gi = 0; gi < KW; gi++) begin : g_slot
      if (BITREV) begin : g_rev
        assign slot_next[gi] = k_next[KW-1-gi];
      end else begin : g_nat
        assign slot_next[gi] = k_next[gi];
      end
    end
  endgenerate

  // last_reg is only ever set in STREAM, so it marks the final sample.
  assign xfer       = (state_reg == STREAM) && out_ready;
  assign final_xfer = xfer && last_reg;
  assign capture    = load && ((state_reg == IDLE) || final_xfer);

  // Frame storage is only written on an accepted load and needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int s = 0; s < N; s++) begin
        frame_reg[s] <= data_in[s*MSB +: MSB];
      end
    end
  end

  // Stream control: capture, advance on handshake, exit after last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      data_out_reg <= '0;
      last_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (load && !capture) begin
        overrun_reg <= 1'b1;
      end
      if (capture) begin
        // Slot 0 comes first in both orders, so take it straight from the input.
        state_reg    <= STREAM;
        k_reg        <= '0;
        data_out_reg <= data_in[MSB-1:0];
        last_reg     <= 1'b0;
      end else if (xfer) begin
        if (last_reg) begin
          state_reg <= IDLE;
          k_reg     <= '0;
          last_reg  <= 1'b0;
        end else begin
          k_reg        <= k_next;
          data_out_reg <= frame_reg[slot_next];
          last_reg     <= (k_next == K_LAST);
        end
      end
    end
  end

  assign data_out  = data_out_reg;
  assign out_valid = (state_reg == STREAM);
  assign busy      = (state_reg == STREAM);
  assign out_index = k_reg;
  assign out_last  = last_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer: natural-order and bit-reversed instances share
// one stimulus stream. Accepted frames are expanded into expected sample
// queues by a frame-level model. A negedge monitor checks each presented sample
// against the queue head and pops it on handshake.
`timescale 1ns/1ps
module tb_fft_out_serializer;

  localparam int N   = 8;
  localparam int MSB = 16;
  localparam int KW  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic             out_ready = 1'b0;
  logic [N*MSB-1:0] data_in = '0;

  logic [MSB-1:0] do0, do1;
  logic [KW-1:0]  idx0, idx1;
  logic           ov0, ov1, last0, last1, busy0, busy1, orun0, orun1;

  always #5 clk = ~clk;

  fft_out_serializer #(.N(N), .MSB(MSB), .BITREV(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .out_ready(out_ready),
    .data_out(do0), .out_valid(ov0), .out_index(idx0), .out_last(last0),
    .busy(busy0), .overrun(orun0)
  );

  fft_out_serializer #(.N(N), .MSB(MSB), .BITREV(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .out_ready(out_ready),
    .data_out(do1), .out_valid(ov1), .out_index(idx1), .out_last(last1),
    .busy(busy1), .overrun(orun1)
  );

  typedef struct packed {
    logic [MSB-1:0] data;
    logic [KW-1:0]  idx;
    logic           last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rem      = 0;     // samples of the current frame not yet transferred
  bit   orun_exp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [KW-1:0] rev(input logic [KW-1:0] k);
    logic [KW-1:0] r;
    for (int b = 0; b < KW; b++) r[b] = k[KW-1-b];
    return r;
  endfunction

  function automatic logic [N*MSB-1:0] make_frame(input logic [MSB-1:0] base);
    logic [N*MSB-1:0] f;
    for (int s = 0; s < N; s++) f[s*MSB +: MSB] = base + MSB'(s);
    return f;
  endfunction

  function automatic logic [N*MSB-1:0] rand_frame();
    logic [N*MSB-1:0] f;
    for (int w = 0; w < N*MSB/32; w++) f[w*32 +: 32] = $urandom;
    return f;
  endfunction

  // Expected stream for one accepted frame, for both output orders.
  task automatic push_frame(input logic [N*MSB-1:0] f);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.idx  = KW'(k);
      e.last = (k == N-1);
      e.data = f[k*MSB +: MSB];
      q0.push_back(e);
      e.data = f[int'(rev(KW'(k)))*MSB +: MSB];
      q1.push_back(e);
    end
  endtask

  // One clock of stimulus; control outputs checked against the frame-level model.
  task automatic step(input logic ld, input logic rdy, input logic [N*MSB-1:0] d);
    bit xfer;
    bit accept;
    load = ld; out_ready = rdy; data_in = d;
    @(negedge clk);
    check("valid0", ov0, rem > 0);
    check("valid1", ov1, rem > 0);
    check("busy0", busy0, rem > 0);
    check("busy1", busy1, rem > 0);
    check("overrun0", orun0, orun_exp);
    check("overrun1", orun1, orun_exp);
    if (rem == 0) begin
      check("idle_index", {idx0, idx1}, '0);
      check("idle_last", {last0, last1}, '0);
    end
    @(posedge clk);
    xfer   = (rem > 0) && rdy;
    accept = ld && ((rem == 0) || (xfer && rem == 1));
    if (ld && !accept) orun_exp = 1'b1;
    if (accept) begin
      push_frame(d);
      rem = N;
    end else if (xfer) begin
      rem--;
    end
    #1;
  endtask

  task automatic do_reset(input logic ld);
    rst = 1'b1; load = ld; out_ready = 1'b1; data_in = rand_frame();
    @(posedge clk);
    #1;
    rst = 1'b0; load = 1'b0;
    rem = 0; orun_exp = 1'b0;
    q0.delete(); q1.delete();
    @(negedge clk);
    check("rst_valid", {ov0, ov1}, '0);
    check("rst_busy", {busy0, busy1}, '0);
    check("rst_overrun", {orun0, orun1}, '0);
    check("rst_index", {idx0, idx1}, '0);
    check("rst_last", {last0, last1}, '0);
    check("rst_data", {do0, do1}, '0);
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input bit which, input logic [MSB-1:0] d, input logic [KW-1:0] i,
                     input logic l, input logic v);
    exp_t e;
    if (!v) return;
    if ((which ? q1.size() : q0.size()) == 0) begin
      check(which ? "unexpected_sample1" : "unexpected_sample0", 1, 0);
      return;
    end
    e = which ? q1[0] : q0[0];
    check(which ? "data1" : "data0", d, e.data);
    check(which ? "index1" : "index0", i, e.idx);
    check(which ? "last1" : "last0", l, e.last);
    if (out_ready) begin
      if (which) void'(q1.pop_front());
      else       void'(q0.pop_front());
    end
  endtask

  // Scoreboard monitor: compare what each DUT presents with the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      mon(1'b0, do0, idx0, last0, ov0);
      mon(1'b1, do1, idx1, last1, ov1);
    end
  end

  initial begin
    logic [N*MSB-1:0] fa;
    logic [N*MSB-1:0] fb;
    bit               done;
    logic             pat [4];
    fa = make_frame(16'h0100);
    fb = make_frame(16'h0200);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    do_reset(1'b0);

    // Continuous ready, both orders.
    step(1'b1, 1'b1, fa);
    repeat (10) step(1'b0, 1'b1, fa);

    // Stalling downstream.
    step(1'b1, 1'b1, fa);
    for (int i = 0; i < 32; i++) step(1'b0, pat[i % 4], '0);

    // Back-to-back frames: second load on the final transfer.
    done = 1'b0;
    step(1'b1, 1'b1, fa);
    for (int i = 0; i < 20; i++) begin
      if (rem == 1 && !done) begin
        step(1'b1, 1'b1, fb);
        done = 1'b1;
      end else begin
        step(1'b0, 1'b1, '0);
      end
    end

    // Load in mid-stream at k=3 is dropped and raises overrun.
    step(1'b1, 1'b1, fa);
    repeat (3) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, fb);
    repeat (12) step(1'b0, 1'b1, '0);

    // Reset at k=5 (with a competing load), then restart.
    do_reset(1'b0);
    step(1'b1, 1'b1, fa);
    repeat (5) step(1'b0, 1'b1, '0);
    do_reset(1'b1);
    step(1'b1, 1'b1, fa);
    repeat (10) step(1'b0, 1'b1, '0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0)
        do_reset(1'($urandom % 2));
      else
        step(($urandom % 6) == 0, ($urandom % 4) != 0, rand_frame());
    end

    repeat (12) step(1'b0, 1'b1, '0);
    check("drained0", q0.size(), 0);
    check("drained1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
